// File: rtl/vrased_pkg.sv
// Shared encodings for the VRASED reset controller: FSM states and cause bit layout.
package vrased_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ASSERT = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    localparam int CAUSE_W       = 7;
    localparam int CAUSE_XSTACK  = 0;
    localparam int CAUSE_AC      = 1;
    localparam int CAUSE_ATOMIC  = 2;
    localparam int CAUSE_DMA_AC  = 3;
    localparam int CAUSE_DMA_DET = 4;
    localparam int CAUSE_DMA_XS  = 5;
    localparam int CAUSE_TIMEOUT = 6;

    localparam int TMR_W = 8;

endpackage

// File: rtl/vrased_rst_timer.sv
// Loadable down-counter with zero flag; shared by the reset hold and the WAIT timeout.
module vrased_rst_timer
    import vrased_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/vrased_reset_ctrl.sv
// VRASED reset controller: holds the core in reset after a monitor violation and
// waits for the PC to reach the reset handler, re-asserting on timeout.
//
// state     | meaning
// ST_IDLE   | no reset pending; cause_clr honoured here
// ST_ASSERT | puc_req high, hold timer counting down
// ST_WAIT   | puc_req low, waiting for pc==RESET_HANDLER or timeout
module vrased_reset_ctrl
    import vrased_pkg::*;
#(
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter int          HOLD_CYCLES   = 4,
    parameter int          WAIT_TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [5:0]         viol,
    input  logic [15:0]        pc,
    input  logic               swatt_exec,
    input  logic               cause_clr,
    output logic               puc_req,
    output logic [CAUSE_W-1:0] cause,
    output logic               cause_valid,
    output logic [7:0]         viol_cnt,
    output logic               att_abort,
    output logic               busy
);

    logic [1:0]         state, state_nxt;
    logic [CAUSE_W-1:0] cause_nxt;
    logic [7:0]         cnt_nxt;
    logic               tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0]   tmr_val;
    logic               enter, timeout;

    vrased_rst_timer u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_nxt = state;
        cause_nxt = cause;
        cnt_nxt   = viol_cnt;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        tmr_dec   = 1'b0;
        enter     = 1'b0;
        timeout   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cause_clr) begin
                    cause_nxt = '0;
                    cnt_nxt   = '0;
                end
                if (viol != '0) enter = 1'b1;
            end
            ST_ASSERT: begin
                cause_nxt[5:0] = cause[5:0] | viol;
                if (tmr_zero) begin
                    state_nxt = ST_WAIT;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(WAIT_TIMEOUT - 1);
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_WAIT: begin
                // A fresh violation outranks the handler match.
                if (viol != '0) begin
                    enter = 1'b1;
                end else if (pc == RESET_HANDLER) begin
                    state_nxt = ST_IDLE;
                    tmr_load  = 1'b1;
                end else if (tmr_zero) begin
                    enter   = 1'b1;
                    timeout = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (enter) begin
            state_nxt      = ST_ASSERT;
            cause_nxt[5:0] = cause_nxt[5:0] | viol;
            if (timeout) cause_nxt[CAUSE_TIMEOUT] = 1'b1;
            tmr_load       = 1'b1;
            tmr_val        = TMR_W'(HOLD_CYCLES - 1);
            if (cnt_nxt != 8'hFF) cnt_nxt = cnt_nxt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            puc_req     <= 1'b0;
            cause       <= '0;
            cause_valid <= 1'b0;
            viol_cnt    <= '0;
            att_abort   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            puc_req     <= (state_nxt == ST_ASSERT);
            cause       <= cause_nxt;
            cause_valid <= |cause_nxt;
            viol_cnt    <= cnt_nxt;
            att_abort   <= enter & swatt_exec;
            busy        <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// Self-checking bench for vrased_reset_ctrl: behavioural model compared every cycle,
// plus directed literal expectations and randomized traffic.
module tb_vrased_reset_ctrl;
    import vrased_pkg::*;

    localparam int HOLD = 4;
    localparam int WT   = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [5:0]  viol = '0;
    logic [15:0] pc = 16'h1234;
    logic        swatt_exec = 1'b0;
    logic        cause_clr = 1'b0;
    logic        puc_req, cause_valid, att_abort, busy;
    logic [6:0]  cause;
    logic [7:0]  viol_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vrased_reset_ctrl #(
        .RESET_HANDLER (16'h0000),
        .HOLD_CYCLES   (HOLD),
        .WAIT_TIMEOUT  (WT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .viol        (viol),
        .pc          (pc),
        .swatt_exec  (swatt_exec),
        .cause_clr   (cause_clr),
        .puc_req     (puc_req),
        .cause       (cause),
        .cause_valid (cause_valid),
        .viol_cnt    (viol_cnt),
        .att_abort   (att_abort),
        .busy        (busy)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: mode 0 idle, 1 holding reset, 2 waiting for handler.
    int         m_mode = 0, m_hold = 0, m_wait = 0, m_cnt = 0;
    logic [6:0] m_cause = '0;
    logic       m_att = 1'b0;
    logic       m_enter, m_tmo;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = 0; m_hold = 0; m_wait = 0; m_cnt = 0;
            m_cause = '0; m_att = 1'b0;
        end else begin
            m_enter = 1'b0;
            m_tmo   = 1'b0;
            m_att   = 1'b0;
            if (m_mode == 0) begin
                if (cause_clr) begin
                    m_cause = '0;
                    m_cnt   = 0;
                end
                if (viol != 0) m_enter = 1'b1;
            end else if (m_mode == 1) begin
                m_cause = m_cause | {1'b0, viol};
                m_hold  = m_hold - 1;
                if (m_hold == 0) begin
                    m_mode = 2;
                    m_wait = 0;
                end
            end else begin
                if (viol != 0) m_enter = 1'b1;
                else if (pc == 16'h0000) m_mode = 0;
                else begin
                    m_wait = m_wait + 1;
                    if (m_wait == WT) begin
                        m_enter = 1'b1;
                        m_tmo   = 1'b1;
                    end
                end
            end
            if (m_enter) begin
                m_mode  = 1;
                m_hold  = HOLD;
                m_cause = m_cause | {m_tmo, viol};
                if (m_cnt < 255) m_cnt = m_cnt + 1;
                m_att   = swatt_exec;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_puc_req",     16'(puc_req),     16'(m_mode == 1));
        chk("m_busy",        16'(busy),        16'(m_mode != 0));
        chk("m_cause",       16'(cause),       16'(m_cause));
        chk("m_cause_valid", 16'(cause_valid), 16'(m_cause != 0));
        chk("m_viol_cnt",    16'(viol_cnt),    16'(m_cnt));
        chk("m_att_abort",   16'(att_abort),   16'(m_att));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        viol = '0;
        pc   = 16'h0000;
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            tick();
        end
        chk("idle_reached", 16'(busy), 16'd0);
        pc = 16'h1234;
    endtask

    initial begin
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_puc", 16'(puc_req), 16'd0);
        chk("rst_cause", 16'(cause), 16'd0);
        chk("rst_cnt", 16'(viol_cnt), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        reset_n = 1'b1;
        tick();

        // Single AC violation, then handler reached on the 3rd WAIT cycle.
        viol = 6'b000010;
        tick();
        viol = '0;
        chk("a_puc_c1", 16'(puc_req), 16'd1);
        chk("a_cause", 16'(cause), 16'h02);
        chk("a_cnt", 16'(viol_cnt), 16'd1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("a_puc_hold", 16'(puc_req), 16'd1);
        end
        tick();
        chk("a_puc_fall", 16'(puc_req), 16'd0);
        chk("a_busy_wait", 16'(busy), 16'd1);
        tick();
        tick();
        pc = 16'h0000;
        tick();
        pc = 16'h1234;
        chk("a_idle_busy", 16'(busy), 16'd0);
        chk("a_idle_cause", 16'(cause), 16'h02);

        // WAIT timeout re-asserts reset.
        cause_clr = 1'b1;
        tick();
        cause_clr = 1'b0;
        chk("b_clr_cause", 16'(cause), 16'd0);
        chk("b_clr_cnt", 16'(viol_cnt), 16'd0);
        viol = 6'b000001;
        tick();
        viol = '0;
        repeat (19) tick();
        chk("b_pre_timeout", 16'(puc_req), 16'd0);
        tick();
        chk("b_reassert", 16'(puc_req), 16'd1);
        chk("b_cause", 16'(cause), 16'h41);
        chk("b_cnt", 16'(viol_cnt), 16'd2);
        wait_idle();

        // Attestation abort pulse.
        swatt_exec = 1'b1;
        viol = 6'b100000;
        tick();
        viol = '0;
        swatt_exec = 1'b0;
        chk("c_att_pulse", 16'(att_abort), 16'd1);
        chk("c_puc_rise", 16'(puc_req), 16'd1);
        tick();
        chk("c_att_single", 16'(att_abort), 16'd0);
        wait_idle();

        // Clear and violation together, then async reset mid-hold.
        cause_clr = 1'b1;
        viol = 6'b000001;
        tick();
        cause_clr = 1'b0;
        viol = '0;
        chk("d_cause", 16'(cause), 16'h01);
        chk("d_busy", 16'(busy), 16'd1);
        chk("d_cnt", 16'(viol_cnt), 16'd1);
        tick();
        #1 reset_n = 1'b0;
        #1;
        chk("d_rst_puc", 16'(puc_req), 16'd0);
        chk("d_rst_cause", 16'(cause), 16'd0);
        chk("d_rst_valid", 16'(cause_valid), 16'd0);
        chk("d_rst_cnt", 16'(viol_cnt), 16'd0);
        chk("d_rst_att", 16'(att_abort), 16'd0);
        chk("d_rst_busy", 16'(busy), 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Continuous violation: one low cycle between holds.
        viol = 6'b000100;
        tick();
        repeat (4) tick();
        chk("e_gap_low", 16'(puc_req), 16'd0);
        tick();
        chk("e_regain", 16'(puc_req), 16'd1);
        repeat (10) tick();
        wait_idle();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            viol       = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            pc         = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'hFFFF));
            swatt_exec = 1'($urandom_range(0, 1));
            cause_clr  = ($urandom_range(0, 9) == 0);
            tick();
        end
        cause_clr  = 1'b0;
        swatt_exec = 1'b0;
        wait_idle();

        // Saturation of the violation counter.
        cause_clr = 1'b1;
        tick();
        cause_clr = 1'b0;
        for (int i = 0; i < 260; i++) begin
            viol = 6'b000001;
            tick();
            wait_idle();
        end
        chk("g_saturate", 16'(viol_cnt), 16'd255);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
